tflite_img_pingpong_buf: RTL and testbench



---
 rtl/tflite_img_pingpong_buf_if.sv | 41 ++++
 rtl/tflite_img_pingpong_buf.sv | 124 ++++++++++++
 tb/tb_tflite_img_pingpong_buf.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tflite_img_pingpong_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : tflite_img_pingpong_buf_if
//  Description : Write-stream and random-read bus of the ping-pong image
//                buffer. The producer/reader side uses master, the buffer
//                uses slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tflite_img_pingpong_buf_if #(
    parameter int IN_W        = 8,
    parameter int RATIO       = 4,
    parameter int FRAME_BYTES = 16384
);
    localparam int OUT_W       = IN_W * RATIO;
    localparam int DEPTH_WORDS = (FRAME_BYTES + RATIO - 1) / RATIO;
    localparam int ADDR_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LEN_W       = $clog2(FRAME_BYTES + 1);

    logic              wr_valid;
    logic              wr_ready;
    logic [IN_W-1:0]   wr_data;
    logic              wr_last;
    logic              rd_frame_avail;
    logic [LEN_W-1:0]  rd_frame_len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [OUT_W-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_release;

    modport master (
        output wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
        input  wr_ready, rd_frame_avail, rd_frame_len, rd_data, rd_valid
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_release,
        output wr_ready, rd_frame_avail, rd_frame_len, rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/tflite_img_pingpong_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tflite_img_pingpong_buf
//  Description : Two-bank frame buffer. Narrow input elements are packed
//                little-endian into wide words of one bank while the reader
//                randomly accesses the other bank; whole frames are handed
//                over by frame-end / release handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tflite_img_pingpong_buf #(
    parameter int IN_W        = 8,
    parameter int RATIO       = 4,
    parameter int FRAME_BYTES = 16384
) (
    input  wire logic                 clk,
    input  wire logic                 resetn,
    tflite_img_pingpong_buf_if.slave  bus
);
    localparam int OUT_W       = IN_W * RATIO;
    localparam int DEPTH_WORDS = (FRAME_BYTES + RATIO - 1) / RATIO;
    localparam int ADDR_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LEN_W       = $clog2(FRAME_BYTES + 1);
    localparam int LANE_W      = (RATIO > 1) ? $clog2(RATIO) : 1;

    // Bank pointers and per-bank frame state
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [1:0]        r_full;
    logic [LEN_W-1:0]  r_len [2];

    // Packing state of the frame being written
    logic [LEN_W-1:0]  r_count;
    logic [LANE_W-1:0] r_lane;
    logic [ADDR_W-1:0] r_waddr;
    logic [OUT_W-1:0]  r_word;

    logic [OUT_W-1:0]  r_mem [2][DEPTH_WORDS];
    logic [OUT_W-1:0]  r_rd_data;
    logic              r_rd_valid;

    logic              w_accept;
    logic              w_frame_end;
    logic              w_commit;
    logic              w_release;
    logic              w_rd_fire;
    logic [LEN_W-1:0]  w_count_inc;
    logic [OUT_W-1:0]  w_word;
    logic [1:0]        w_full_nxt;

    assign bus.wr_ready       = !r_full[r_wr_bank];
    assign bus.rd_frame_avail = r_full[r_rd_bank];
    assign bus.rd_frame_len   = r_full[r_rd_bank] ? r_len[r_rd_bank] : '0;
    assign bus.rd_data        = r_rd_data;
    assign bus.rd_valid       = r_rd_valid;

    assign w_accept    = bus.wr_valid && bus.wr_ready;
    assign w_count_inc = r_count + LEN_W'(1);
    // A frame closes on wr_last or when the element budget is exhausted
    assign w_frame_end = w_accept && (bus.wr_last || (w_count_inc == LEN_W'(FRAME_BYTES)));
    assign w_commit    = w_accept && ((r_lane == LANE_W'(RATIO - 1)) || w_frame_end);
    assign w_release   = bus.rd_release && r_full[r_rd_bank];
    assign w_rd_fire   = bus.rd_en && r_full[r_rd_bank];

    // Insert the incoming element into its lane; higher lanes are still zero
    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        assign w_word[g*IN_W +: IN_W] = (r_lane == LANE_W'(g)) ? bus.wr_data
                                                              : r_word[g*IN_W +: IN_W];
    end

    // Next full flags: writer and reader always touch different banks
    always_comb begin
        w_full_nxt = r_full;
        if (w_frame_end) w_full_nxt[r_wr_bank] = 1'b1;
        if (w_release)   w_full_nxt[r_rd_bank] = 1'b0;
    end

    // Bank handshake and write-side packing state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_full    <= 2'b00;
            r_len[0]  <= '0;
            r_len[1]  <= '0;
            r_count   <= '0;
            r_lane    <= '0;
            r_waddr   <= '0;
            r_word    <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_frame_end) begin
                r_len[r_wr_bank] <= w_count_inc;
                r_wr_bank        <= ~r_wr_bank;
            end
            if (w_release) r_rd_bank <= ~r_rd_bank;
            if (w_accept) begin
                r_count <= w_frame_end ? '0 : w_count_inc;
                r_lane  <= w_commit ? '0 : r_lane + LANE_W'(1);
                r_word  <= w_commit ? '0 : w_word;
                if (w_frame_end)   r_waddr <= '0;
                else if (w_commit) r_waddr <= r_waddr + ADDR_W'(1);
            end
        end
    end

    // Bank RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (resetn && w_commit) r_mem[r_wr_bank][r_waddr] <= w_word;
    end

    // Registered read port; data holds between reads, out-of-range reads give 0
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data <= (32'(bus.rd_addr) < DEPTH_WORDS) ? r_mem[r_rd_bank][bus.rd_addr] : '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tflite_img_pingpong_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tflite_img_pingpong_buf
//  Description : Directed bench for the ping-pong image buffer; read results
//                are checked by a scoreboard monitor per instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tflite_img_pingpong_buf;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    tflite_img_pingpong_buf_if #(.IN_W(8), .RATIO(4), .FRAME_BYTES(16384)) bus_a ();
    tflite_img_pingpong_buf_if #(.IN_W(8), .RATIO(4), .FRAME_BYTES(10))    bus_b ();

    tflite_img_pingpong_buf #(.IN_W(8), .RATIO(4), .FRAME_BYTES(16384)) dut_a (
        .clk(clk), .resetn(resetn), .bus(bus_a));
    tflite_img_pingpong_buf #(.IN_W(8), .RATIO(4), .FRAME_BYTES(10)) dut_b (
        .clk(clk), .resetn(resetn), .bus(bus_b));

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for instance A
    initial forever begin
        @(negedge clk);
        if (bus_a.rd_valid === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_rd_valid: got rd_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_rd_data", bus_a.rd_data, e.data);
                chk("a_rd_latency", cyc, e.cyc);
            end
        end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL a_missing_rd_valid: got rd_valid=0 expected 1 (cycle %0d)", cyc);
            void'(qa.pop_front());
        end
    end

    // Scoreboard monitor for instance B
    initial forever begin
        @(negedge clk);
        if (bus_b.rd_valid === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_rd_valid: got rd_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_rd_data", bus_b.rd_data, e.data);
                chk("b_rd_latency", cyc, e.cyc);
            end
        end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL b_missing_rd_valid: got rd_valid=0 expected 1 (cycle %0d)", cyc);
            void'(qb.pop_front());
        end
    end

    task automatic wr_a(input logic [7:0] d, input logic last);
        bus_a.wr_valid = 1'b1; bus_a.wr_data = d; bus_a.wr_last = last;
        tick();
        bus_a.wr_valid = 1'b0; bus_a.wr_last = 1'b0;
    endtask

    task automatic wr_b(input logic [7:0] d, input logic last);
        bus_b.wr_valid = 1'b1; bus_b.wr_data = d; bus_b.wr_last = last;
        tick();
        bus_b.wr_valid = 1'b0; bus_b.wr_last = 1'b0;
    endtask

    task automatic rd_a(input int addr, input logic [31:0] exp);
        bus_a.rd_en = 1'b1; bus_a.rd_addr = 12'(addr);
        qa.push_back('{exp, cyc + 1});
        tick();
        bus_a.rd_en = 1'b0;
    endtask

    task automatic rd_b(input int addr, input logic [31:0] exp);
        bus_b.rd_en = 1'b1; bus_b.rd_addr = 2'(addr);
        qb.push_back('{exp, cyc + 1});
        tick();
        bus_b.rd_en = 1'b0;
    endtask

    task automatic rel_a();
        bus_a.rd_release = 1'b1;
        tick();
        bus_a.rd_release = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Global time bound
    initial begin
        #1000000;
        errors++;
        $display("FAIL timeout: simulation did not complete in time");
        finish_run();
    end

    initial begin
        bus_a.wr_valid = 0; bus_a.wr_data = 0; bus_a.wr_last = 0;
        bus_a.rd_en = 0; bus_a.rd_addr = 0; bus_a.rd_release = 0;
        bus_b.wr_valid = 0; bus_b.wr_data = 0; bus_b.wr_last = 0;
        bus_b.rd_en = 0; bus_b.rd_addr = 0; bus_b.rd_release = 0;
        do_reset();

        // Reset state
        chk("rst_wr_ready", 32'(bus_a.wr_ready), 1);
        chk("rst_avail", 32'(bus_a.rd_frame_avail), 0);
        chk("rst_len", 32'(bus_a.rd_frame_len), 0);
        chk("rst_rd_valid", 32'(bus_a.rd_valid), 0);
        chk("rst_rd_data", bus_a.rd_data, 0);

        // Full-size frame with byte k = k%256
        for (int k = 0; k < 16384; k++) begin
            if (k == 16383) chk("big_avail_before_end", 32'(bus_a.rd_frame_avail), 0);
            wr_a(8'(k), k == 16383);
        end
        chk("big_avail", 32'(bus_a.rd_frame_avail), 1);
        chk("big_len", 32'(bus_a.rd_frame_len), 16384);
        chk("big_wr_ready", 32'(bus_a.wr_ready), 1);
        rd_a(0, 32'h03020100);
        rd_a(1, 32'h07060504);
        rd_a(4095, 32'hFFFEFDFC);
        rel_a();
        chk("rel_avail", 32'(bus_a.rd_frame_avail), 0);
        chk("rel_len", 32'(bus_a.rd_frame_len), 0);

        // Read with nothing available is ignored and data holds
        bus_a.rd_en = 1'b1; bus_a.rd_addr = 0;
        tick();
        bus_a.rd_en = 1'b0;
        chk("noavail_rd_valid", 32'(bus_a.rd_valid), 0);
        chk("noavail_rd_data_hold", bus_a.rd_data, 32'hFFFEFDFC);

        // Short frame into bank 1
        for (int k = 0; k < 6; k++) wr_a(8'(8'h11 + k), k == 5);
        chk("short_avail", 32'(bus_a.rd_frame_avail), 1);
        chk("short_len", 32'(bus_a.rd_frame_len), 6);
        chk("short_wr_ready", 32'(bus_a.wr_ready), 1);
        rd_a(0, 32'h14131211);
        rd_a(1, 32'h00001615);

        // Second frame fills the other bank: backpressure
        for (int k = 0; k < 4; k++) wr_a(8'(8'hA0 + k), k == 3);
        chk("bp_wr_ready", 32'(bus_a.wr_ready), 0);
        chk("bp_len", 32'(bus_a.rd_frame_len), 6);
        bus_a.wr_valid = 1'b1; bus_a.wr_data = 8'hEE; bus_a.wr_last = 1'b1;
        repeat (2) tick();
        bus_a.wr_valid = 1'b0; bus_a.wr_last = 1'b0;
        chk("bp_hold_wr_ready", 32'(bus_a.wr_ready), 0);

        // Same-cycle read and release: read served from released bank
        bus_a.rd_en = 1'b1; bus_a.rd_addr = 0; bus_a.rd_release = 1'b1;
        qa.push_back('{32'h14131211, cyc + 1});
        tick();
        bus_a.rd_en = 1'b0; bus_a.rd_release = 1'b0;
        chk("swap_avail", 32'(bus_a.rd_frame_avail), 1);
        chk("swap_len", 32'(bus_a.rd_frame_len), 4);
        chk("swap_wr_ready", 32'(bus_a.wr_ready), 1);
        rd_a(0, 32'hA3A2A1A0);

        // Frame end on one bank and release of the other in the same cycle
        wr_a(8'hB0, 1'b0);
        bus_a.wr_valid = 1'b1; bus_a.wr_data = 8'hB1; bus_a.wr_last = 1'b1;
        bus_a.rd_release = 1'b1;
        tick();
        bus_a.wr_valid = 1'b0; bus_a.wr_last = 1'b0; bus_a.rd_release = 1'b0;
        chk("both_wr_ready", 32'(bus_a.wr_ready), 1);
        chk("both_avail", 32'(bus_a.rd_frame_avail), 1);
        chk("both_len", 32'(bus_a.rd_frame_len), 2);
        rd_a(0, 32'h0000B1B0);

        // Reset in the middle of a frame
        for (int k = 0; k < 100; k++) wr_a(8'(k), 1'b0);
        repeat (2) tick();
        do_reset();
        chk("midrst_wr_ready", 32'(bus_a.wr_ready), 1);
        chk("midrst_avail", 32'(bus_a.rd_frame_avail), 0);
        chk("midrst_len", 32'(bus_a.rd_frame_len), 0);
        chk("midrst_rd_data", bus_a.rd_data, 0);
        for (int k = 0; k < 4; k++) wr_a(8'(8'hC0 + k), k == 3);
        chk("post_rst_avail", 32'(bus_a.rd_frame_avail), 1);
        chk("post_rst_len", 32'(bus_a.rd_frame_len), 4);
        rd_a(0, 32'hC3C2C1C0);

        // Small instance: frame closes on element budget
        for (int k = 0; k < 10; k++) begin
            if (k == 9) chk("b_avail_before_end", 32'(bus_b.rd_frame_avail), 0);
            wr_b(8'(k + 1), 1'b0);
        end
        chk("b_avail", 32'(bus_b.rd_frame_avail), 1);
        chk("b_len", 32'(bus_b.rd_frame_len), 10);
        chk("b_wr_ready", 32'(bus_b.wr_ready), 1);
        rd_b(0, 32'h04030201);
        rd_b(1, 32'h08070605);
        rd_b(2, 32'h00000A09);
        rd_b(3, 32'h00000000);

        repeat (4) tick();
        chk("a_pending_reads", 32'(qa.size()), 0);
        chk("b_pending_reads", 32'(qb.size()), 0);
        finish_run();
    end
endmodule
`default_nettype wire
